// File: rtl/piano_key_redraw_seq.sv
// piano_key_redraw_seq
// Redraw sequencer for the on-screen piano keyboard. It tracks the state last
// drawn for each key and, whenever a key's current state differs from it,
// walks that key's sprite one pixel per clock. Each walk presents a
// sprite-ROM address first. One cycle later it presents the aligned
// (x, y, colour, plot) to the VGA adapter. Only one key is drawn at a time,
// and the lowest pending index goes first.
//
// Ports:
//   Clock      system clock
//   Resetn     synchronous, active-low reset
//   key_state  per-key pressed level (1 = draw "on" sprite)
//   clr_off    key_off ROM data, 1-cycle read latency
//   clr_on     key_on ROM data, 1-cycle read latency
//   rom_addr   {yc, xc} to both sprite ROMs
//   vga_x      pixel x
//   vga_y      pixel y
//   vga_color  pixel colour (selected ROM word)
//   plot       pixel write strobe
//   busy       high while a key sprite is being walked
//
// Optional build macro: PIANO_KEY_SYNC_EN. When it is defined, key_state
// passes through a 2-flop synchronizer before the pending logic.
//
// FSM states:
//   state  | meaning
//   S_IDLE | nothing being drawn; start the lowest pending key
//   S_DRAW | walking sprite pixels of key idx
module piano_key_redraw_seq #(
  parameter int NUM_KEYS = 7,
  parameter int KEY_W    = 16,
  parameter int KEY_H    = 33,
  parameter int X0       = 24,
  parameter int Y0       = 42,
  parameter int PITCH    = 16
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [NUM_KEYS-1:0] key_state,
  input  logic [2:0]          clr_off,
  input  logic [2:0]          clr_on,
  output logic [11:0]         rom_addr,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [2:0]          vga_color,
  output logic                plot,
  output logic                busy
);

  typedef enum logic {S_IDLE, S_DRAW} state_t;

  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] key_s;
  logic [NUM_KEYS-1:0] drawn;
  logic [NUM_KEYS-1:0] init;
  logic [NUM_KEYS-1:0] pending;
  logic [2:0]          idx;
  logic [2:0]          first_idx;
  logic                sel;
  logic                sel_q;
  logic [4:0]          xc;
  logic [6:0]          yc;
  logic                row_end;
  logic                last_pix;

`ifdef PIANO_KEY_SYNC_EN
  logic [NUM_KEYS-1:0] sync_1;
  logic [NUM_KEYS-1:0] sync_2;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= key_state;
      sync_2 <= sync_1;
    end
  end

  assign key_s = sync_2;
`else
  assign key_s = key_state;
`endif

  // A key needs drawing if it was never drawn since reset, or if its state
  // has moved away from what is on screen.
  assign pending  = init | (key_s ^ drawn);
  assign row_end  = (xc == 5'(KEY_W - 1));
  assign last_pix = row_end && (yc == 7'(KEY_H - 1));
  assign rom_addr = {yc, xc};

  // The downward scan leaves the lowest set bit in first_idx.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) first_idx = 3'(i);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|pending) state_d = S_DRAW;
      end
      S_DRAW: begin
        busy = 1'b1;
        if (last_pix) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      idx   <= '0;
      sel   <= 1'b0;
      xc    <= '0;
      yc    <= '0;
      drawn <= '0;
      init  <= '1;
      plot  <= 1'b0;
      vga_x <= '0;
      vga_y <= '0;
      sel_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && |pending) begin
        idx <= first_idx;
        sel <= key_s[first_idx];
        xc  <= '0;
        yc  <= '0;
      end
      if (state_q == S_DRAW) begin
        if (row_end) begin
          xc <= '0;
          yc <= yc + 7'd1;
        end else begin
          xc <= xc + 5'd1;
        end
        // drawn takes the select latched at the start of the sprite. A key
        // that changed meanwhile therefore stays pending and is redrawn.
        if (last_pix) begin
          drawn[idx] <= sel;
          init[idx]  <= 1'b0;
        end
      end
      // The output stage is registered so that it lines up with the ROM data.
      plot  <= (state_q == S_DRAW);
      vga_x <= 8'(X0) + 8'(idx) * 8'(PITCH) + 8'(xc);
      vga_y <= 7'(Y0) + yc;
      sel_q <= sel;
    end
  end

  assign vga_color = sel_q ? clr_on : clr_off;

endmodule

// File: tb/tb_piano_key_redraw_seq.sv
module tb_piano_key_redraw_seq;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [6:0]  key_state;
  logic [2:0]  clr_off, clr_on;
  logic [11:0] rom_addr;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_color;
  logic        plot, busy;

  piano_key_redraw_seq dut (
    .Clock(Clock), .Resetn(Resetn), .key_state(key_state),
    .clr_off(clr_off), .clr_on(clr_on), .rom_addr(rom_addr),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
    .plot(plot), .busy(busy)
  );

  always #5 Clock = ~Clock;

  // Sprite ROMs: 1-cycle latency. The word is derived from the address, and
  // the two ROMs differ so that a wrong select shows up in the colour.
  logic [11:0] rom_q;
  always @(posedge Clock) rom_q <= rom_addr;
  assign clr_off = rom_q[2:0];
  assign clr_on  = rom_q[2:0] ^ 3'b101;

  typedef struct { int idx; bit sel; } burst_t;
  burst_t sb[$];
  burst_t cur;
  int     vec  = 0;
  int     errs = 0;
  bit     in_burst = 0;
  int     pix = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every plot burst must match the next expected key in the
  // scoreboard, pixel by pixel, and it must last exactly 528 cycles.
  always @(negedge Clock) begin
    if (!Resetn) begin
      in_burst = 0;
      pix      = 0;
    end else if (plot) begin
      if (!in_burst) begin
        chk("burst_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) cur = sb.pop_front();
        else begin cur.idx = -1; cur.sel = 0; end
        in_burst = 1;
        pix      = 0;
      end
      begin
        int xcv, ycv;
        logic [2:0] col;
        xcv = pix % 16;
        ycv = pix / 16;
        col = 3'(xcv);
        if (cur.sel) col = col ^ 3'b101;
        chk("pix_x", 32'(vga_x), 32'(24 + cur.idx * 16 + xcv));
        chk("pix_y", 32'(vga_y), 32'(42 + ycv));
        chk("pix_color", 32'(vga_color), 32'(col));
      end
      pix++;
    end else if (in_burst) begin
      in_burst = 0;
      chk("burst_len", 32'(pix), 32'd528);
    end
  end

  task automatic wait_idle(input int budget);
    bit done = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge Clock); #1;
      if (sb.size() == 0 && !in_burst && !busy && !plot) begin done = 1; break; end
    end
    chk("idle_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_pix(input int k, input int n);
    bit done = 0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge Clock); #1;
      if (in_burst && cur.idx == k && pix >= n) begin done = 1; break; end
    end
    chk("pix_timeout", 32'(done), 32'd1);
  endtask

  // Entered with Resetn already low. Holds reset for 2 edges, then releases
  // it and checks the full 7-key redraw with key_state = 0.
  task automatic reset_and_draw();
    @(posedge Clock); #1;
    chk("rst_plot", 32'(plot), 32'd0);
    @(posedge Clock); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vga_x", 32'(vga_x), 32'd0);
    chk("rst_vga_y", 32'(vga_y), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_color", 32'(vga_color), 32'(clr_off));
    chk("rst_drawn", 32'(dut.drawn), 32'd0);
    chk("rst_init", 32'(dut.init), 32'h7f);
    #1 Resetn = 1'b1;
    for (int k = 0; k < 7; k++) sb.push_back('{k, 1'b0});
    @(posedge Clock); #1;
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_plot0", 32'(plot), 32'd0);
    @(posedge Clock); #1;
    chk("lat_plot1", 32'(plot), 32'd1);
    repeat (3700) @(posedge Clock);
    #1 chk("busy_at_3702", 32'(busy), 32'd1);
    @(posedge Clock); #1;
    chk("busy_at_3703", 32'(busy), 32'd0);
    wait_idle(100);
    chk("drawn_after_full", 32'(dut.drawn), 32'd0);
    chk("init_after_full", 32'(dut.init), 32'd0);
  endtask

  initial begin
    Resetn    = 1'b0;
    key_state = 7'b0;
    reset_and_draw();

    // Single press of key 2
    #1 key_state = 7'b0000100;
    sb.push_back('{2, 1'b1});
    wait_idle(2000);
    for (int c = 0; c < 10; c++) begin
      @(posedge Clock); #1;
      chk("idle_plot", 32'(plot), 32'd0);
    end
    chk("drawn_single", 32'(dut.drawn), 32'h04);

    // Release key 2, then reset at pixel 300 of its redraw
    #1 key_state = 7'b0;
    sb.push_back('{2, 1'b0});
    wait_pix(2, 300);
    #1 Resetn = 1'b0;
    sb.delete();
    reset_and_draw();

    // Simultaneous changes on keys 1 and 6
    #1 key_state = 7'b1000010;
    sb.push_back('{1, 1'b1});
    sb.push_back('{6, 1'b1});
    wait_idle(3000);
    chk("drawn_simul", 32'(dut.drawn), 32'h42);

    // Key 3 pressed, then released 100 pixels into its burst
    #1 key_state = 7'b1001010;
    sb.push_back('{3, 1'b1});
    wait_pix(3, 100);
    #1 key_state = 7'b1000010;
    sb.push_back('{3, 1'b0});
    wait_idle(3000);
    chk("drawn3_cleared", 32'(dut.drawn[3]), 32'd0);
    chk("drawn_final", 32'(dut.drawn), 32'h42);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/piano_key_redraw_seq.md
# piano_key_redraw_seq

Redraw sequencer for the on-screen piano keyboard. Watches the 7 piano-key pressed states and, whenever a key's state differs from what was last drawn, walks that key's sprite pixel by pixel. For each pixel it issues a sprite-ROM address, then presents the aligned (x, y, colour, plot) to the downstream `vga_adapter`, one pixel per clock. It replaces free-running per-key counters and the one-hot output mux: exactly one key is drawn at a time, and every state change is eventually drawn.

## Interface
Parameters:
- NUM_KEYS, 7, number of keys; index width is 3 bits.
- KEY_W, 16, sprite width in pixels (actual width, not width-1).
- KEY_H, 33, sprite height in pixels.
- X0, 24, x of key 0's left column.
- Y0, 42, y of every key's top row.
- PITCH, 16, x spacing between adjacent keys.

Ports:
- Clock  in  1  system clock (CLOCK_50).
- Resetn  in  1  synchronous, active-low reset.
- key_state  in  NUM_KEYS  level per key; 1 = pressed (draw "on" sprite).
- clr_off  in  3  `key_off` ROM data; 1-cycle read latency.
- clr_on  in  3  `key_on` ROM data; 1-cycle read latency.
- rom_addr  out  12  {yc[6:0], xc[4:0]} to both sprite ROMs.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_color  out  3  pixel colour.
- plot  out  1  pixel write strobe.
- busy  out  1  high while a key is being drawn.

## Operation
- The block keeps a `drawn` register (NUM_KEYS bits) holding the state that was last drawn for each key.
- The block keeps an `init` register (NUM_KEYS bits) that forces the first draw of every key after reset.
- pending[i] = init[i] | (key_state[i] ^ drawn[i]).
- **IDLE:**
  - busy=0.
  - If pending≠0, go to DRAW at the next edge.
  - On that edge, latch idx = lowest set pending bit, latch sel = key_state[idx], and clear xc and yc.
- **DRAW:**
  - busy=1.
  - Every cycle, rom_addr={yc,xc}.
  - xc increments every cycle. At xc==KEY_W-1, xc wraps to 0 and yc increments.
  - At (xc==KEY_W-1, yc==KEY_H-1), the block does the following at that edge:
    - drawn[idx]←sel.
    - init[idx]←0.
    - Go to IDLE.
- **Priority:** lowest pending index first. A key is never preempted mid-sprite.
- **Key change during DRAW:**
  - If the key being drawn changes, it is ignored until completion.
  - On completion, drawn≠key_state, so the key becomes pending again and is redrawn.
  - No state change is ever lost. The final screen always matches the stable key_state.
- **Output stage** (registered, aligns with ROM latency):
  - plot ← (state==DRAW).
  - vga_x ← X0 + idx·PITCH + xc, computed in 8 bits, wraps mod 256.
  - vga_y ← Y0 + yc, computed in 7 bits, wraps mod 128.
  - sel_q ← sel.
- vga_color = sel_q ? clr_on : clr_off. This is combinational from ROM outputs and the registered select.
- Parameters must keep all coordinates within 160×120. The block does not clip.

## Timing
- **Reset values:**
  - plot=0, busy=0, vga_x=0, vga_y=0, rom_addr=0.
  - sel_q=0, so vga_color=clr_off.
  - drawn=0, init=all ones, state=IDLE, idx=0.
- **Reset mid-DRAW:** aborts the sprite. plot is 0 at the next cycle and all 7 keys are redrawn afterwards.
- **Latency:**
  - pending rising in IDLE → busy=1 at the next edge.
  - First plot=1 is one cycle after busy rises.
- **Per key:**
  - plot is high for exactly KEY_W·KEY_H = 528 consecutive cycles.
  - The last plot occurs the cycle after busy falls.
- **Between keys:** the FSM spends at least one IDLE cycle, and plot=0 for ≥1 cycle between sprites.
- **After reset:** full keyboard draw takes 7×529 = 3703 cycles.

## Configuration
- **`PIANO_KEY_SYNC_EN` defined:**
  - key_state passes through a 2-flop synchronizer, reset to 0, before pending logic.
  - This adds 2 cycles of latency from a key_state change to pending.
- **Not defined:** key_state is used directly and must already be synchronous to Clock.

## Test plan
- **Reset full draw:** Resetn low 2 cycles, key_state=0 → 7 plot bursts of 528 cycles each, in key order 0..6.
  - Key 0 burst: first pixel (24,42), last pixel (39,74).
  - Key 6 burst: first pixel (120,42).
  - All pixels use clr_off. busy falls after 3703 cycles.
- **Single press:** after initial draw, set key_state=7'b0000100 → one burst at x 56..71, y 42..74, colour=clr_on. Then idle with plot=0.
- **Simultaneous changes:** set key_state 0→7'b1000010 in one cycle → key 1 burst (x 40..55), ≥1 idle cycle, then key 6 burst (x 120..135).
- **Change mid-draw:** press key 3, release it 100 cycles into its burst → key 3 burst completes with clr_on, then a second key 3 burst with clr_off; drawn[3]=0 at end.
- **Reset mid-operation:** assert Resetn low at pixel 300 of key 2 → plot=0 the next cycle; after release, full 7-key redraw as in the reset full-draw scenario.
- **ROM alignment:** model both ROMs with 1-cycle latency and content = address → for every plot cycle, vga_color equals the ROM word for (vga_x−X0−idx·PITCH, vga_y−Y0).
